// File: rtl/fetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Synchronous instruction-memory bus: the fetch unit is master, the memory is slave.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_renable;
  logic [3:0]      mem_mask;

  modport master (
    output mem_addr, mem_wdata, mem_renable, mem_mask,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_renable, mem_mask,
    output mem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push, pop is
// a no-op against a simultaneous flush since the whole buffer is discarded.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the storage is reset too, so instr_data/instr_pc read 0 out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr[AW-1:0]] <= push_entry;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign head  = mem_q[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads, buffers returns, serves decode, handles redirects.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  mem,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [XLEN-1:0]     instr_data,
  output logic [XLEN-1:0]     instr_pc,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                fetch_misalign
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = AW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] issue_addr;
  logic            inflight;
  logic            halted;
  logic            bad_redirect;
  logic            pop;
  logic            push;
  logic            issue;
  logic [AW:0]     count;
  logic [OW-1:0]   occupancy;
  fetch_entry_t    head;
  fetch_entry_t    resp;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky until the next redirect; only an aligned redirect resumes fetch.
  always_ff @(posedge clk) begin
    if (reset)               halted <= 1'b0;
    else if (redirect_valid) halted <= bad_redirect;
  end

  assign fetch_misalign = halted;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign bad_redirect    = 1'b0;
  assign halted          = 1'b0;
`endif

  assign pop  = instr_valid && instr_ready;
  assign push = inflight && !redirect_valid;

  // Slots committed after this cycle; pop cannot exceed count, so no underflow.
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    issue = 1'b0;
    if (!reset) begin
      if (redirect_valid) issue = !bad_redirect;
      else                issue = !halted && (occupancy < OW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    issue_addr = fetch_pc;
    if (reset)                        issue_addr = RESET_PC;
    else if (redirect_valid && issue) issue_addr = target_pc;
  end

  assign mem.mem_renable = issue;
  assign mem.mem_addr    = issue_addr;
  assign mem.mem_wdata   = '0;
  assign mem.mem_mask    = 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc   <= issue_addr;
        fetch_pc <= issue_addr + PC_STEP;
      end
    end
  end

  assign resp.pc    = req_pc;
  assign resp.instr = mem.mem_rdata;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (resp),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

  assign instr_valid = (count != '0);
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

endmodule
